// File: rtl/spy_pkg.sv
// Shared FSM encoding and readout-window arithmetic for the spy buffer readout path.
package spy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_READ,
        ST_DRAIN,
        ST_RELEASE
    } spy_state_t;

    localparam int unsigned SKID_DEPTH = 2;

    // Word count actually read: 0 or anything beyond the memory depth selects full depth.
    function automatic logic [31:0] spy_eff_len(input logic [31:0] len, input int unsigned aw);
        logic [31:0] depth;
        logic [31:0] result;
        depth = 32'(1) << aw;
        if (len == 32'd0 || len > depth) begin
            result = depth;
        end else begin
            result = len;
        end
        return result;
    endfunction

    // Oldest address of an N-word window ending at the write pointer; full depth lands on wend.
    function automatic logic [31:0] spy_start_addr(input logic [31:0] wend, input logic [31:0] len,
                                                    input int unsigned aw);
        logic [31:0] mask;
        mask = (32'(1) << aw) - 32'd1;
        return (wend - len) & mask;
    endfunction

endpackage

// File: rtl/spy_rd_skid.sv
// Two-entry buffer catching spy memory read data; head entry drives the readout stream directly.
module spy_rd_skid
    import spy_pkg::*;
#(
    parameter int unsigned WIDTH = 66
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] ent0_q;
    logic [WIDTH-1:0] ent1_q;
    logic [1:0]       count_q;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'(SKID_DEPTH)) || do_pop);

    // Entry 0 is always the oldest word, so the stream output never moves while stalled.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_q <= push_data;
                    end else begin
                        ent1_q <= push_data;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    ent0_q  <= ent1_q;
                    ent1_q  <= '0;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_q <= push_data;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head      = ent0_q;
    assign valid     = (count_q != 2'd0);
    assign occupancy = count_q;

endmodule

// File: rtl/spy_readout_sequencer.sv
// Freezes the spy buffer, reads back the most recent N words in address order as a
// valid/ready stream, then releases the freeze.
module spy_readout_sequencer
    import spy_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned SPY_MEM_WIDTH = 7,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [SPY_MEM_WIDTH:0]   rd_len,
    output logic                     freeze,
    input  logic [SPY_MEM_WIDTH-1:0] spy_write_addr,
    output logic                     spy_read_enable,
    output logic [SPY_MEM_WIDTH-1:0] spy_read_addr,
    input  logic [DATA_WIDTH:0]      spy_data,
    output logic [DATA_WIDTH:0]      out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AW          = SPY_MEM_WIDTH;
    localparam int unsigned LW          = SPY_MEM_WIDTH + 1;
    localparam int unsigned WW          = DATA_WIDTH + 1;
    localparam int unsigned CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    spy_state_t        state_q;
    spy_state_t        state_d;
    logic              freeze_q;
    logic              freeze_d;
    logic              busy_q;
    logic              busy_d;
    logic              done_q;
    logic              done_d;

    logic [CW-1:0]     settle_cnt_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     rem_q;
    logic [AW-1:0]     raddr_q;
    logic              pend_q;
    logic              pend_last_q;

    logic              settle_done;
    logic              pop;
    logic [2:0]        credit_used;
    logic              issue;
    logic              last_issue;
    logic              flush;
    logic [WW:0]       skid_head;
    logic              skid_valid;
    logic [1:0]        skid_occ;

    assign settle_done = (state_q == ST_SETTLE) && (settle_cnt_q == CW'(SETTLE_LAST));
    assign pop         = skid_valid && out_ready;
    assign flush       = abort && (state_q != ST_IDLE);

    // Read credit: words already buffered plus the one on the memory bus, less the word leaving now.
    assign credit_used = 3'(skid_occ) + 3'(pend_q) - 3'(pop);
    assign issue       = (state_q == ST_READ) && !abort && !reset && (credit_used < 3'(SKID_DEPTH));
    assign last_issue  = issue && (rem_q == LW'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            freeze_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            freeze_q <= freeze_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        freeze_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_done) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && skid_head[WW]) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
        freeze_d = (state_d == ST_SETTLE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
        busy_d   = freeze_d;
        done_d   = (state_d == ST_RELEASE);
    end

    // Length is latched at start and the window origin at the final settle cycle; later input
    // changes cannot disturb the readout in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            settle_cnt_q <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            raddr_q      <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
        end else begin
            pend_q      <= issue;
            pend_last_q <= last_issue;
            unique case (state_q)
                ST_IDLE: begin
                    settle_cnt_q <= '0;
                    if (start && !abort) begin
                        len_q <= LW'(spy_eff_len(32'(rd_len), AW));
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + CW'(1);
                    if (settle_done) begin
                        raddr_q <= AW'(spy_start_addr(32'(spy_write_addr), 32'(len_q), AW));
                        rem_q   <= len_q;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        raddr_q <= raddr_q + AW'(1);
                        rem_q   <= rem_q - LW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    spy_rd_skid #(
        .WIDTH (WW + 1)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (pend_q),
        .push_data ({pend_last_q, spy_data}),
        .pop       (out_ready),
        .head      (skid_head),
        .valid     (skid_valid),
        .occupancy (skid_occ)
    );

    assign freeze          = freeze_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign spy_read_enable = issue;
    assign spy_read_addr   = raddr_q;
    assign out_data        = skid_head[WW-1:0];
    assign out_last        = skid_head[WW];
    assign out_valid       = skid_valid;

endmodule

// File: tb/tb_spy_readout_sequencer.sv
// Bench for spy_readout_sequencer: spy memory model, vector table of readout windows and
// a scoreboard of expected words, plus abort/reset/start corner sequences.
module tb_spy_readout_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  rd_len;
    logic        freeze;
    logic [6:0]  spy_write_addr;
    logic        spy_read_enable;
    logic [6:0]  spy_read_addr;
    logic [64:0] spy_data;
    logic [64:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    typedef struct {
        logic [6:0] wend;
        logic [7:0] len;
        int         ready_pct;
        int         n;
        logic [6:0] first;
    } vec_t;

    typedef struct packed {
        logic [64:0] data;
        logic        last;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_pass;
    int   n_total;

    spy_readout_sequencer #(
        .DATA_WIDTH    (64),
        .SPY_MEM_WIDTH (7),
        .SETTLE_CYCLES (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .rd_len          (rd_len),
        .freeze          (freeze),
        .spy_write_addr  (spy_write_addr),
        .spy_read_enable (spy_read_enable),
        .spy_read_addr   (spy_read_addr),
        .spy_data        (spy_data),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [64:0] word_of(input int a);
        return {a[0], 32'hC0DE_0000 | 32'(a), 32'(a * a + 7)};
    endfunction

    // Synchronous spy memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clock) begin
        spy_data <= spy_read_enable ? word_of(int'(spy_read_addr)) : {65{1'b1}};
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic run_readout(input vec_t v);
        exp_t        e;
        int          beats;
        bit          seen_done;
        bit          stalled;
        logic [64:0] held_d;
        logic        held_l;
        beats     = 0;
        seen_done = 1'b0;
        stalled   = 1'b0;
        held_d    = '0;
        held_l    = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            e.data = word_of((int'(v.first) + i) % 128);
            e.last = (i == v.n - 1);
            sb.push_back(e);
        end
        spy_write_addr = ~v.wend;
        rd_len         = v.len;
        start          = 1'b1;
        @(negedge clock);
        start          = 1'b0;
        rd_len         = ~v.len;
        spy_write_addr = v.wend + 7'h11;
        check("busy_after_start", busy, 1);
        check("freeze_after_start", freeze, 1);
        @(negedge clock);
        spy_write_addr = v.wend;
        @(negedge clock);
        spy_write_addr = v.wend ^ 7'h5A;
        for (int k = 0; k < 4000; k++) begin
            start = (k == 1);
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_d);
                check("stall_last", out_last, held_l);
            end
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            out_ready = ($urandom_range(99) < v.ready_pct);
            if (out_valid && out_ready) begin
                beats++;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: actual %0h required none", out_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_last", out_last, e.last);
                end
            end
            stalled = out_valid && !out_ready;
            held_d  = out_data;
            held_l  = out_last;
            @(negedge clock);
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        check("beat_count", beats, v.n);
        check("sb_empty", sb.size(), 0);
        check("done_freeze_low", freeze, 0);
        check("done_busy_low", busy, 0);
        check("done_valid_low", out_valid, 0);
        sb.delete();
        @(negedge clock);
        check("done_single_pulse", done, 0);
        out_ready = 1'b1;
    endtask

    task automatic abort_sequence();
        int accepted;
        bit reached;
        bit any_done;
        bit any_valid;
        accepted       = 0;
        reached        = 1'b0;
        any_done       = 1'b0;
        any_valid      = 1'b0;
        spy_write_addr = 7'h30;
        rd_len         = 8'd16;
        out_ready      = 1'b1;
        start          = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (out_valid && accepted == 4) begin
                reached = 1'b1;
                break;
            end
            if (out_valid) accepted++;
            @(negedge clock);
        end
        check("abort_reached_5th", reached, 1);
        check("abort_5th_word", out_data, word_of(32'h24));
        abort     = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        abort = 1'b0;
        check("abort_valid_low", out_valid, 0);
        check("abort_freeze_low", freeze, 0);
        check("abort_busy_low", busy, 0);
        check("abort_done_low", done, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            any_done  = any_done | done;
            any_valid = any_valid | out_valid;
        end
        check("abort_no_done", any_done, 0);
        check("abort_no_valid", any_valid, 0);
    endtask

    task automatic reset_sequence();
        bit any_done;
        bit any_busy;
        any_done       = 1'b0;
        any_busy       = 1'b0;
        spy_write_addr = 7'h50;
        rd_len         = 8'd16;
        out_ready      = 1'b0;
        start          = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("rst_pre_busy", busy, 1);
        check("rst_pre_valid", out_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_freeze", freeze, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", spy_read_enable, 0);
        check("rst_rd_addr", spy_read_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            any_done = any_done | done;
            any_busy = any_busy | busy;
        end
        check("rst_no_done", any_done, 0);
        check("rst_stays_idle", any_busy, 0);
    endtask

    task automatic start_abort_idle();
        bit any_busy;
        any_busy = 1'b0;
        rd_len   = 8'd4;
        start    = 1'b1;
        abort    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy_low", busy, 0);
        check("sa_freeze_low", freeze, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            any_busy = any_busy | busy | done;
        end
        check("sa_no_readout", any_busy, 0);
    endtask

    initial begin
        vecs[0] = '{7'h10, 8'd0,   100, 128, 7'h10};
        vecs[1] = '{7'h03, 8'd8,   100, 8,   7'h7B};
        vecs[2] = '{7'h40, 8'd4,   30,  4,   7'h3C};
        vecs[3] = '{7'h00, 8'd1,   100, 1,   7'h7F};
        vecs[4] = '{7'h20, 8'd200, 100, 128, 7'h20};
        vecs[5] = '{7'h7F, 8'd128, 60,  128, 7'h7F};
        vecs[6] = '{7'h05, 8'd129, 100, 128, 7'h05};
        vecs[7] = '{7'h66, 8'd127, 100, 127, 7'h67};

        n_pass         = 0;
        n_total        = 0;
        reset          = 1'b1;
        start          = 1'b0;
        abort          = 1'b0;
        rd_len         = 8'd0;
        spy_write_addr = 7'd0;
        out_ready      = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_freeze", freeze, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", spy_read_enable, 0);
        check("reset_rd_addr", spy_read_addr, 0);
        check("reset_valid", out_valid, 0);
        check("reset_last", out_last, 0);
        check("reset_data", out_data, 0);
        reset = 1'b0;
        @(negedge clock);

        foreach (vecs[i]) run_readout(vecs[i]);
        abort_sequence();
        run_readout(vecs[1]);
        reset_sequence();
        start_abort_idle();
        run_readout(vecs[2]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spy_readout_sequencer.md
SPY_READOUT_SEQUENCER -- requirements
Module: spy_readout_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning spy word is DATA_WIDTH+1 bits (data plus metadata bit).
REQ-002 SHALL have parameter SPY_MEM_WIDTH, default 7, meaning the spy memory holds 2^SPY_MEM_WIDTH words.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles held in freeze before the write pointer is sampled.
REQ-004 SHALL have port clock, input, 1 bit: the single clock, the spy write clock domain.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: readout request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: cancel an in-progress readout.
REQ-008 SHALL have port rd_len, input, SPY_MEM_WIDTH+1 bits: number of most-recent words to read; 0 or any value above 2^SPY_MEM_WIDTH means full depth.
REQ-009 SHALL have port freeze, output, 1 bit: drives the spy buffer freeze.
REQ-010 SHALL have port spy_write_addr, input, SPY_MEM_WIDTH bits: the spy memory write pointer.
REQ-011 SHALL have port spy_read_enable, output, 1 bit: spy memory read strobe.
REQ-012 SHALL have port spy_read_addr, output, SPY_MEM_WIDTH bits: spy memory read address.
REQ-013 SHALL have port spy_data, input, DATA_WIDTH+1 bits: spy memory read data, valid exactly 1 cycle after the strobe.
REQ-014 SHALL have ports out_data (output, DATA_WIDTH+1 bits), out_valid (output, 1 bit), out_ready (input, 1 bit) and out_last (output, 1 bit) forming the readout stream.
REQ-015 SHALL have ports busy (output, 1 bit) and done (output, 1 bit, single-cycle pulse).

Function
REQ-016 SHALL implement states IDLE, SETTLE, READ, DRAIN, RELEASE.
REQ-017 IDLE: when start=1, SHALL go to SETTLE and assert freeze and busy from the next cycle.
REQ-018 SETTLE: SHALL count SETTLE_CYCLES cycles, then sample spy_write_addr as wend and go to READ.
REQ-019 READ: SHALL set raddr = wend - N mod 2^SPY_MEM_WIDTH, where N is the effective rd_len latched at start; with full depth, raddr = wend, the oldest entry.
REQ-020 READ: SHALL issue one strobe per cycle while in-flight reads plus buffered words are fewer than 2; raddr SHALL increment modulo 2^SPY_MEM_WIDTH, wrapping from all-ones to 0.
REQ-021 After the N-th strobe, SHALL go to DRAIN; the N-th word delivered SHALL have out_last=1.
REQ-022 DRAIN: once all N words are accepted (out_valid and out_ready both 1), SHALL go to RELEASE.
REQ-023 RELEASE: SHALL deassert freeze and busy, pulse done for exactly 1 cycle, and return to IDLE.
REQ-024 Stream SHALL follow valid/ready rules: out_data, out_valid and out_last stay stable while out_valid=1 and out_ready=0; words SHALL be delivered in address order with no loss or duplication.
REQ-025 With out_ready held at 1, SHALL sustain 1 word per cycle after a 1-cycle initial latency.
REQ-026 abort in any state other than IDLE SHALL, on the next cycle, flush buffered and in-flight data, drop out_valid, deassert freeze and busy, return to IDLE, and SHALL NOT pulse done.
REQ-027 If start and abort are both 1 in IDLE, abort SHALL win and no readout starts.
REQ-028 start asserted while busy SHALL be ignored.
REQ-029 Changes on rd_len or spy_write_addr after they are latched SHALL have no effect on the current readout.

Reset
REQ-030 While reset=1, SHALL hold state IDLE with freeze, busy, done, spy_read_enable, out_valid and out_last at 0, spy_read_addr and out_data at 0, and counters and buffer cleared.
REQ-031 Reset asserted mid-readout SHALL take precedence over all inputs and SHALL NOT pulse done.

Structure
REQ-032 The state enumeration and the effective-length/start-address arithmetic helper SHALL live in a shared spy_pkg package.
REQ-033 A 2-entry skid buffer sub-module, spy_rd_skid, SHALL hold returning read data and provide the occupancy used for read credit.

Verification
REQ-034 Bench SHALL cover: SPY_MEM_WIDTH=7, wend=0x10, rd_len=0, out_ready=1 -> 128 words from addresses 0x10..0x7F then 0x00..0x0F, last word with out_last=1, then done.
REQ-035 Bench SHALL cover: wend=0x03, rd_len=8 -> addresses 0x7B..0x7F then 0x00..0x02; 8 words, wrap across 0.
REQ-036 Bench SHALL cover: rd_len=4 with out_ready random at 30% -> exactly 4 words, stable while stalled, no duplicates.
REQ-037 Bench SHALL cover: abort at the 5th word of 16 -> out_valid=0 and freeze=0 next cycle, no done, and a new start then completes normally.
REQ-038 Bench SHALL cover: reset pulsed during READ -> all outputs 0 next cycle; start pulsed while busy -> ignored.
REQ-039 Bench SHALL cover: spy_write_addr changing during SETTLE -> the value sampled on the final SETTLE cycle is used.
